// File: rtl/mem_responder_pkg.sv
// Shared types and defaults for the memory responder and the datapath.
// Holds the FSM state encoding and the default bus widths.
package mem_responder_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Controller <-> memory handshake bundle: rd/wr requests with addr/wdata,
// rdata/mfc/perr back. master = controller side, slave = memory side.
interface mem_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) ();

  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              mfc;
  logic              perr;

  modport master (
    output rd, wr, addr, wdata,
    input  rdata, mfc, perr
  );

  modport slave (
    input  rd, wr, addr, wdata,
    output rdata, mfc, perr
  );

endinterface

// File: rtl/mem_array.sv
// Single-port synchronous RAM, DATA_W x 2**ADDR_W, with registered read.
// Ports: clk, rst (async, clears rdata only), we, re, addr, wdata, rdata.
module mem_array #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Storage is deliberately not reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read register holds its value until the next read completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder for the rd/wr/mfc handshake with programmable wait states.
// Ports: clk, rstIn (async active-high), bus (slave: rd wr addr wdata
// in; rdata mfc perr out). Optional MEM_RESP_PROT_EN write-protects
// addresses below PROT_LIMIT.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int WAIT_CYCLES = 2,
  parameter int PROT_LIMIT  = 16
) (
  input  logic            clk,
  input  logic            rstIn,
  mem_responder_if.slave  bus
);

  localparam logic [CNT_W-1:0] WAIT_LD =
    CNT_W'(WAIT_CYCLES);
  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);

`ifdef MEM_RESP_PROT_EN
  localparam bit PROT_ON = 1'b1;
`else
  localparam bit PROT_ON = 1'b0;
`endif

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_lat;
  logic [DATA_W-1:0] wdata_lat;
  logic              op_wr;
  logic              mfc_q;
  logic              perr_q;
  logic [DATA_W-1:0] rdata_q;

  logic              req_any;
  logic              req_one;
  logic              req_both;
  logic              enter_done;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic              cur_wr;
  logic              prot_hit;
  logic              we;
  logic              re;

  assign req_any  = bus.rd | bus.wr;
  assign req_one  = bus.rd ^ bus.wr;
  assign req_both = bus.rd & bus.wr;

  // With zero wait states the commit happens on the sample edge,
  // so the array must see the live inputs instead of the latches.
  always_comb begin
    enter_done = 1'b0;
    cur_addr   = addr_lat;
    cur_wdata  = wdata_lat;
    cur_wr     = op_wr;
    unique case (state)
      IDLE: begin
        cur_addr   = bus.addr;
        cur_wdata  = bus.wdata;
        cur_wr     = bus.wr;
        enter_done = req_one & ZERO_WAIT;
      end
      WAIT: begin
        enter_done = req_any & (cnt == CNT_W'(1));
      end
      default: ;
    endcase
  end

  // Folds to constant 0 when protection is compiled out.
  assign prot_hit = PROT_ON & cur_wr &
                    (int'(cur_addr) < PROT_LIMIT);

  assign we = enter_done & cur_wr & ~prot_hit;
  assign re = enter_done & ~cur_wr;

  always_ff @(posedge clk or posedge rstIn) begin
    if (rstIn) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_lat  <= '0;
      wdata_lat <= '0;
      op_wr     <= 1'b0;
      mfc_q     <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      perr_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_both) begin
            perr_q <= 1'b1;
          end else if (req_one) begin
            addr_lat  <= bus.addr;
            wdata_lat <= bus.wdata;
            op_wr     <= bus.wr;
            cnt       <= WAIT_LD;
            if (ZERO_WAIT) begin
              state  <= DONE;
              mfc_q  <= 1'b1;
              perr_q <= prot_hit;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!req_any) begin
            state  <= IDLE;
            cnt    <= '0;
            perr_q <= 1'b1;
          end else if (cnt == CNT_W'(1)) begin
            state  <= DONE;
            cnt    <= '0;
            mfc_q  <= 1'b1;
            perr_q <= prot_hit;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          // Leaving on this edge; the next request is sampled
          // no earlier than the following edge.
          if (!req_any) begin
            state <= IDLE;
            mfc_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          mfc_q <= 1'b0;
        end
      endcase
    end
  end

  mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .rst   (rstIn),
    .we    (we),
    .re    (re),
    .addr  (cur_addr),
    .wdata (cur_wdata),
    .rdata (rdata_q)
  );

  assign bus.rdata = rdata_q;
  assign bus.mfc   = mfc_q;
  assign bus.perr  = perr_q;

endmodule
